ram_dual_host_arb: RTL



---
 rtl/ram_arb_pkg.sv | 25 ++
 rtl/rr_arb2.sv | 38 +++
 rtl/ram_dual_host_arb.sv | 121 ++++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared types and window helper for the dual-host RAM front end
package ram_arb_pkg;

    typedef enum logic {
        HostA = 1'b0,
        HostB = 1'b1
    } host_e;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } ram_req_t;

    // Unsigned offset compare: addresses below base wrap to large offsets and miss.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] size);
        logic [31:0] off;
        off = addr - base;
        return off < size;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin arbiter, preferred host flips after every grant
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o,
    output host_e      winner_o
);

    host_e prio_q;
    host_e prio_d;

    always_comb begin
        gnt_o    = 2'b00;
        winner_o = HostA;
        prio_d   = prio_q;
        if (req_i[0] && (!req_i[1] || prio_q == HostA)) begin
            gnt_o    = 2'b01;
            winner_o = HostA;
            prio_d   = HostB;
        end else if (req_i[1]) begin
            gnt_o    = 2'b10;
            winner_o = HostB;
            prio_d   = HostA;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q <= HostA;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/ram_dual_host_arb.sv
// rtl/ram_dual_host_arb.sv - arbitrates instruction and data hosts onto one single-port RAM
module ram_dual_host_arb
    import ram_arb_pkg::*;
#(
    parameter int          Depth    = 128,
    parameter logic [31:0] BaseAddr = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        a_req_i,
    input  logic        a_we_i,
    input  logic [3:0]  a_be_i,
    input  logic [31:0] a_addr_i,
    input  logic [31:0] a_wdata_i,
    output logic        a_gnt_o,
    output logic        a_rvalid_o,
    output logic [31:0] a_rdata_o,
    output logic        a_err_o,

    input  logic        b_req_i,
    input  logic        b_we_i,
    input  logic [3:0]  b_be_i,
    input  logic [31:0] b_addr_i,
    input  logic [31:0] b_wdata_i,
    output logic        b_gnt_o,
    output logic        b_rvalid_o,
    output logic [31:0] b_rdata_o,
    output logic        b_err_o,

    output logic        ram_req_o,
    output logic        ram_we_o,
    output logic [3:0]  ram_be_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_wdata_o,
    input  logic        ram_rvalid_i,
    input  logic [31:0] ram_rdata_i
);

    localparam logic [31:0] WinBytes = 32'(Depth * 4);

    logic [1:0] gnt;
    host_e      winner;
    ram_req_t   a_req_s;
    ram_req_t   b_req_s;
    ram_req_t   win_req;
    logic       any_gnt;
    logic       win_hit;

    host_e      rsp_owner_q, rsp_owner_d;
    logic       rsp_err_q,   rsp_err_d;
    logic       rsp_pend_q,  rsp_pend_d;
    logic       rsp_valid;
    logic       a_owns;
    logic       b_owns;

    rr_arb2 u_arb (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req_i    ({b_req_i, a_req_i}),
        .gnt_o    (gnt),
        .winner_o (winner)
    );

    assign a_gnt_o = gnt[0];
    assign b_gnt_o = gnt[1];

    always_comb begin
        a_req_s = '{we: a_we_i, be: a_be_i, addr: a_addr_i, wdata: a_wdata_i};
        b_req_s = '{we: b_we_i, be: b_be_i, addr: b_addr_i, wdata: b_wdata_i};
        win_req = (winner == HostB) ? b_req_s : a_req_s;
        any_gnt = |gnt;
        win_hit = in_window(win_req.addr, BaseAddr, WinBytes);
    end

    // Misses are granted and answered locally; the RAM never sees them.
    always_comb begin
        ram_req_o   = any_gnt & win_hit;
        ram_we_o    = win_req.we;
        ram_be_o    = win_req.be;
        ram_addr_o  = win_req.addr;
        ram_wdata_o = win_req.wdata;
    end

    always_comb begin
        rsp_owner_d = winner;
        rsp_err_d   = any_gnt & ~win_hit;
        rsp_pend_d  = any_gnt;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_owner_q <= HostA;
            rsp_err_q   <= 1'b0;
            rsp_pend_q  <= 1'b0;
        end else begin
            rsp_owner_q <= rsp_owner_d;
            rsp_err_q   <= rsp_err_d;
            rsp_pend_q  <= rsp_pend_d;
        end
    end

    // rdata is gated by the pending flag so nothing leaks out during or right after reset.
    always_comb begin
        rsp_valid  = rsp_pend_q & (rsp_err_q | ram_rvalid_i);
        a_owns     = rsp_pend_q & (rsp_owner_q == HostA);
        b_owns     = rsp_pend_q & (rsp_owner_q == HostB);
        a_rvalid_o = rsp_valid & a_owns;
        b_rvalid_o = rsp_valid & b_owns;
        a_err_o    = a_rvalid_o & rsp_err_q;
        b_err_o    = b_rvalid_o & rsp_err_q;
        a_rdata_o  = (a_owns && !rsp_err_q) ? ram_rdata_i : 32'h0;
        b_rdata_o  = (b_owns && !rsp_err_q) ? ram_rdata_i : 32'h0;
    end

    ram_rvalid_unexpected : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        ram_rvalid_i |-> (rsp_pend_q && !rsp_err_q)
    );

endmodule
